oam_dma: RTL and testbench

OAM_DMA -- requirements
Module: oam_dma

---
 rtl/oam_dma_pkg.sv | 6 +
 rtl/oam_dma.sv | 55 +++++
 tb/tb_oam_dma.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/oam_dma_pkg.sv
// oam_dma_pkg: shared state encoding and default bus addresses for the sprite DMA
package oam_dma_pkg;
    typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} dma_state_t;
    localparam logic [15:0] DEF_DMA_REG_ADDR  = 16'h4014;
    localparam logic [15:0] DEF_OAM_DATA_ADDR = 16'h2004;
endpackage

// File: rtl/oam_dma.sv
// oam_dma: halts the CPU and copies one 256-byte page into the PPU OAM data port
module oam_dma
    import oam_dma_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR  = DEF_DMA_REG_ADDR,
    parameter logic [15:0] OAM_DATA_ADDR = DEF_OAM_DATA_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_wr_i,
    input  logic [15:0] cpu_addr_i,
    input  logic [7:0]  cpu_wdata_i,
    output logic        cpu_rdy_o,
    output logic        bus_own_o,
    output logic [15:0] bus_addr_o,
    output logic        bus_we_o,
    output logic [7:0]  bus_wdata_o,
    input  logic [7:0]  bus_rdata_i
);
    dma_state_t state, nxt;
    logic [7:0] page, cnt;
    logic       parity, trig;
    assign trig = cpu_wr_i && cpu_addr_i == DMA_REG_ADDR && state == IDLE;
    // State, page latch, byte counter and the free-running cycle parity
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            page   <= '0;
            cnt    <= '0;
            parity <= 1'b0;
        end else begin
            state  <= nxt;
            parity <= ~parity;
            if (trig) page <= cpu_wdata_i;
            if (state == WRITE) cnt <= cnt + 8'd1;
        end
    end
    // Next state and bus drive; ALIGN presents the first source address as a harmless dummy read
    always_comb begin
        nxt         = IDLE;
        cpu_rdy_o   = state == IDLE;
        bus_own_o   = state inside {ALIGN, READ, WRITE};
        bus_we_o    = state == WRITE;
        bus_addr_o  = state == WRITE ? OAM_DATA_ADDR : state inside {ALIGN, READ} ? {page, cnt} : 16'h0000;
        bus_wdata_o = state == WRITE ? bus_rdata_i : 8'h00;
        case (state)
            IDLE:    nxt = trig ? HALT : IDLE;
            HALT:    nxt = parity ? ALIGN : READ;
            ALIGN:   nxt = READ;
            READ:    nxt = WRITE;
            WRITE:   nxt = cnt == 8'hFF ? IDLE : READ;
            default: nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: directed checks of stall length, page copy order, trigger filtering and reset abort
module tb_oam_dma;
    import oam_dma_pkg::*;
    logic        clk = 1'b0, rst = 1'b1, cpu_wr_i = 1'b0;
    logic [15:0] cpu_addr_i = 16'h0000;
    logic [7:0]  cpu_wdata_i = 8'h00;
    logic        cpu_rdy_o, bus_own_o, bus_we_o;
    logic [15:0] bus_addr_o;
    logic [7:0]  bus_wdata_o, bus_rdata_i;
    int n_cmp = 0, n_fail = 0;
    int cyc = 0, n_wr = 0, n_own = 0, n_stall = 0, n_err = 0, n_zero = 0;
    int s0, o0, w0, e0, z0;
    logic [15:0] prev_addr = 16'h0000, last_rd = 16'h0000;
    logic [7:0]  exp_lo = 8'h00, exp_page = 8'h00;

    oam_dma dut (
        .clk(clk), .rst(rst), .cpu_wr_i(cpu_wr_i), .cpu_addr_i(cpu_addr_i),
        .cpu_wdata_i(cpu_wdata_i), .cpu_rdy_o(cpu_rdy_o), .bus_own_o(bus_own_o),
        .bus_addr_o(bus_addr_o), .bus_we_o(bus_we_o), .bus_wdata_o(bus_wdata_o),
        .bus_rdata_i(bus_rdata_i)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_f(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // Synchronous-read memory: data for the address presented appears after the edge
    always @(posedge clk) bus_rdata_i <= mem_f(bus_addr_o);

    // Edge count since reset; its low bit tracks the DUT parity flop
    always @(posedge clk or posedge rst) cyc <= rst ? 0 : cyc + 1;

    // Bus monitor: each OAM write must carry the byte read from the next in-page address
    always @(negedge clk) begin
        if (cpu_rdy_o) exp_lo = 8'h00;
        else n_stall++;
        if (bus_own_o) n_own++;
        if (bus_own_o && bus_addr_o == 16'h0000) n_zero++;
        if (bus_own_o && bus_we_o) begin
            n_wr++;
            if (bus_addr_o !== DEF_OAM_DATA_ADDR || prev_addr !== {exp_page, exp_lo}
                || bus_wdata_o !== mem_f(prev_addr)) n_err++;
            last_rd = prev_addr;
            exp_lo++;
        end
        prev_addr = bus_addr_o;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        cpu_wr_i = 1'b1; cpu_addr_i = a; cpu_wdata_i = d;
        tick();
        cpu_wr_i = 1'b0;
    endtask

    task automatic start(input logic [7:0] pg, input bit par);
        s0 = n_stall; o0 = n_own; w0 = n_wr; e0 = n_err; z0 = n_zero;
        exp_page = pg;
        if (((cyc + 1) % 2) != int'(par)) tick();
        cpu_write(DEF_DMA_REG_ADDR, pg);
        check("halt_rdy", cpu_rdy_o, 0);
        check("halt_own", bus_own_o, 0);
        check("halt_addr", bus_addr_o, 0);
        tick();
        check("post_halt_rdy", cpu_rdy_o, 0);
        check("post_halt_own", bus_own_o, 1);
        check("post_halt_we", bus_we_o, 0);
    endtask

    task automatic wait_wr(input int n);
        for (int i = 0; i < 2000 && n_wr - w0 < n; i++) tick();
        check("wr_reached", n_wr - w0, n);
    endtask

    task automatic finish_xfer(input int exp_stall);
        for (int i = 0; i < 1000 && !cpu_rdy_o; i++) tick();
        check("done", cpu_rdy_o, 1);
        check("stall", n_stall - s0, exp_stall);
        check("own_cycles", n_own - o0, exp_stall - 1);
        check("writes", n_wr - w0, 256);
        check("bad_writes", n_err - e0, 0);
    endtask

    initial begin
        repeat (3) tick();
        check("rst_rdy", cpu_rdy_o, 1);
        check("rst_own", bus_own_o, 0);
        check("rst_addr", bus_addr_o, 0);
        check("rst_we", bus_we_o, 0);
        check("rst_wdata", bus_wdata_o, 0);
        @(negedge clk) rst = 1'b0;
        tick();
        // page 02, parity 0: no ALIGN, 513-cycle stall
        start(8'h02, 1'b0);
        finish_xfer(513);
        check("last_rd_02", last_rd, 16'h02FF);
        // parity 1: one ALIGN cycle; a trigger during the final WRITE is dropped
        start(8'h02, 1'b1);
        wait_wr(255);
        tick();
        check("final_we", bus_we_o, 1);
        cpu_write(DEF_DMA_REG_ADDR, 8'h07);
        finish_xfer(514);
        tick(); tick();
        check("late_trig_rdy", cpu_rdy_o, 1);
        check("late_trig_own", bus_own_o, 0);
        // top page must stay within FF00-FFFF
        start(8'hFF, 1'b0);
        finish_xfer(513);
        check("last_rd_ff", last_rd, 16'hFFFF);
        check("zero_access", n_zero - z0, 0);
        // retrigger mid-transfer must not change the page
        start(8'h02, 1'b0);
        wait_wr(100);
        cpu_write(DEF_DMA_REG_ADDR, 8'h05);
        finish_xfer(513);
        // reset after the 10th OAM write aborts the copy
        start(8'h02, 1'b0);
        wait_wr(10);
        rst = 1'b1;
        #1;
        check("abort_rdy", cpu_rdy_o, 1);
        check("abort_own", bus_own_o, 0);
        check("abort_addr", bus_addr_o, 0);
        check("abort_we", bus_we_o, 0);
        check("abort_wdata", bus_wdata_o, 0);
        repeat (2) tick();
        @(negedge clk) rst = 1'b0;
        repeat (20) tick();
        check("abort_writes", n_wr - w0, 10);
        check("abort_idle", cpu_rdy_o, 1);
        start(8'h02, 1'b0);
        finish_xfer(513);
        // writes to neighbouring registers never start a transfer
        s0 = n_stall; o0 = n_own;
        cpu_write(16'h4015, 8'h03);
        cpu_write(DEF_OAM_DATA_ADDR, 8'h03);
        repeat (4) tick();
        check("other_rdy", cpu_rdy_o, 1);
        check("other_stall", n_stall - s0, 0);
        check("other_own", n_own - o0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
